// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encodings, op-class helpers and the queued entry layout.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } mdu_entry_t;

  // Multi-cycle ops: these keep the unit busy after they start.
  function automatic logic is_muldiv(input logic [3:0] t);
    return (t >= MDU_MULT) && (t <= MDU_DIVU);
  endfunction

  function automatic logic is_enq(input logic [3:0] t);
    return is_muldiv(t) || (t == MDU_MTHI) || (t == MDU_MTLO);
  endfunction

  function automatic logic is_read(input logic [3:0] t);
    return (t == MDU_MFHI) || (t == MDU_MFLO);
  endfunction

endpackage

// File: rtl/mdu_fifo.sv
// Generic synchronous circular-buffer FIFO; head is visible the cycle after a write.
// Push is ignored when full and pop is ignored when empty.
module mdu_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int WIDTH = 68
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mdu_issue_queue.sv
// In-order issue queue in front of the multiply/divide unit; stalls mfhi/mflo until older ops finish.
// Optional macro MDU_ISSUE_BYPASS_EN: enqueue ops reaching an empty queue and idle unit issue the same cycle.
module mdu_issue_queue
  import mdu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       in_type,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             stall,
  output logic [3:0]       mdu_type,
  output logic [31:0]      mdu_a,
  output logic [31:0]      mdu_b,
  input  logic             mdu_busy,
  output logic [PTR_W:0]   q_count
);

  mdu_entry_t in_entry;
  mdu_entry_t head;
  logic       full;
  logic       empty;
  logic       issued_q;
  logic       idle;
  logic       enq_req;
  logic       rd_req;
  logic       issue;
  logic       pass;
  logic       byp;
  logic       push;

  assign in_entry = '{op: in_type, a: in_a, b: in_b};

  // mdu_busy lags a start by a cycle; issued_q covers that hole.
  assign idle    = !mdu_busy && !issued_q && !reset;
  assign enq_req = in_valid && is_enq(in_type);
  assign rd_req  = in_valid && is_read(in_type);
  assign issue   = !empty && idle;
  assign pass    = rd_req && empty && idle;

`ifdef MDU_ISSUE_BYPASS_EN
  assign byp = enq_req && empty && idle;
`else
  assign byp = 1'b0;
`endif

  // At full a push is refused even if the head pops this cycle.
  assign push  = enq_req && !full && !byp;
  assign stall = !reset && ((enq_req && full) || (rd_req && !pass));

  mdu_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH ($bits(mdu_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_entry),
    .pop       (issue),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (q_count)
  );

  always_comb begin
    mdu_type = MDU_NONE;
    mdu_a    = '0;
    mdu_b    = '0;
    if (issue) begin
      mdu_type = head.op;
      mdu_a    = head.a;
      mdu_b    = head.b;
    end else if (pass || byp) begin
      mdu_type = in_type;
      mdu_a    = in_a;
      mdu_b    = in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) issued_q <= 1'b0;
    else       issued_q <= (issue && is_muldiv(head.op)) || (byp && is_muldiv(in_type));
  end

endmodule

// File: doc/mdu_issue_queue.md
Name: mdu_issue_queue

Overview:
- Sits between the E-stage operand path and the multiply/divide unit. Buffers mult/multu/div/divu/mthi/mtlo requests in a small in-order FIFO, so back-to-back MDU ops do not freeze the pipeline while the unit is busy.
- Issues one queued op to the unit each time the unit is idle.
- Forwards mfhi/mflo only when every older op has completed. Otherwise it raises a stall.

Parameters:
- DEPTH, 4, queue entries; power of two, ≥2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  E stage presents an MDU-class instruction
- in_type  in  4  op code: 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
- in_a  in  32  rs operand (forwarded)
- in_b  in  32  rt operand (forwarded)
- stall  out  1  freeze the F/D/E stages this cycle
- mdu_type  out  4  type driven to the unit (0 = idle)
- mdu_a  out  32  operand A to the unit
- mdu_b  out  32  operand B to the unit
- mdu_busy  in  1  unit busy flag (registered; rises the cycle after a start)
- q_count  out  PTR_W+1  current occupancy

Behaviour:
- Classes:
  - Enqueue ops: types 1-4, 7, 8.
  - Read ops: types 5, 6.
  - Type 0 or in_valid=0: no request.
- State: circular buffer with rd_ptr/wr_ptr (PTR_W bits, wrap DEPTH-1→0), count (PTR_W+1 bits), and a 1-bit issued_q.
  - issued_q is set for exactly the cycle after a type 1-4 issue, covering the one-cycle gap before mdu_busy rises.
- idle = !mdu_busy && !issued_q.
- Issue, combinational:
  - If count>0 && idle: drive the head entry on mdu_type/a/b, pop it at the clock edge, and set issued_q if the head type is 1-4.
  - mthi/mtlo issue with issued_q=0, so the next entry may issue the following cycle.
- Read op passthrough:
  - If count==0 && idle && no issue this cycle: drive in_type/in_a/in_b straight through, with stall=0. The unit returns HI/LO combinationally.
  - Otherwise stall=1 and mdu_type=0.
- Enqueue:
  - Accepted at the edge when count<DEPTH; stall=0.
  - If count==DEPTH, stall=1 and nothing is written. This holds even when a pop occurs the same cycle: no simultaneous enqueue+dequeue at full.
  - Below full, simultaneous push and pop leaves count unchanged.
- Ordering: strictly FIFO; ops reach the unit in program order.
- Minimum enqueue→issue latency is 1 cycle; the entry is visible at the head the cycle after it is written.
- Default outputs:
  - mdu_type=0 and mdu_a=mdu_b=0 whenever no issue and no passthrough.
  - stall=0 when in_valid=0.
- Reset:
  - count=0, ptrs=0, issued_q=0, stall=0, mdu_type=0, mdu_a=0, mdu_b=0, q_count=0.
  - Entry contents are don't-care.
  - Reset mid-operation discards all queued ops. The unit's own reset clears its in-flight op.
- Assumption: the pipeline holds in_* stable while stall=1.

Optional Feature:
- Macro: MDU_ISSUE_BYPASS_EN.
- Defined: an enqueue op arriving with count==0 && idle is driven directly to the unit the same cycle and is not written to the queue. issued_q is set as for a normal issue, and stall=0.
- Undefined: every enqueue op passes through the queue, with the 1-cycle minimum latency.

Decomposition:
- Shared package (mdu_pkg) holds:
  - MDU type encodings MDU_NONE=0 … MDU_MTLO=8.
  - is_enq/is_read helper functions.
  - Entry struct {type[3:0], a[31:0], b[31:0]}.
- One sub-module: mdu_fifo, a generic DEPTH×68-bit sync FIFO.
  - Ports: push/pop/full/empty/count.
  - The issue/stall logic stays in mdu_issue_queue.

Test Plan:
1. mult in_a=3,in_b=5 with unit idle → queued, issued next cycle with mdu_type=1, stall=0; after completion a later mflo passes through and the unit returns 15.
2. Back-to-back div, mult, mthi(7) → no stalls; issue order is 3, 1, 7. Each issue waits for mdu_busy to fall; mthi issues on the first idle cycle after mult completes.
3. Five enqueue ops in consecutive cycles while the unit is busy, DEPTH=4 → the fifth cycle has stall=1 with q_count=4. It is accepted the cycle after the first pop.
4. mfhi while count=2 → stall asserted until the queue is empty and the unit is idle. Then mdu_type=5 passes through with stall=0, and HI equals the result of the last queued op.
5. Reset asserted with count=3 and the unit busy → next cycle q_count=0, stall=0, mdu_type=0; a new mtlo enqueues and issues normally.
6. With MDU_ISSUE_BYPASS_EN, multu 0xFFFFFFFF×2 with queue empty and unit idle → mdu_type=2 the same cycle and q_count stays 0. Without the macro, it issues one cycle later.
